ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_pkg.sv | 26 ++
 rtl/ifu_fetch_fsm.sv | 93 +++++++++
 rtl/ifu_fetch_reg.sv | 21 ++
 rtl/ifu_fetch.sv | 94 +++++++++
 tb/tb_ifu_fetch.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared configuration for the instruction fetch unit: widths, NOP encoding,
// FSM state encoding and PC-register select codes.
package ifu_fetch_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned INST_LEN = 32;

   // addi x0, x0, 0
   localparam logic [INST_LEN-1:0] INST_NOP = 32'h0000_0013;

   // IDLE: request pending, WAIT: one request outstanding, HOLD: instruction held
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   // Load selects for the PC registers
   typedef enum logic [1:0] {
      PC_KEEP = 2'd0,
      PC_NEXT = 2'd1,
      PC_TGT  = 2'd2,
      PC_INC  = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/ifu_fetch_fsm.sv
// Fetch control FSM: owns the state and the drop flag, and tells the datapath
// which PC registers to load and when to capture a response.
module ifu_fsm
   import ifu_fetch_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_req_ready,
   input  logic    i_resp_valid,
   input  logic    i_redirect,
   input  logic    i_ready,
   output logic    o_req_valid,
   output logic    o_valid,
   output pc_sel_e o_fpc_sel,
   output pc_sel_e o_npc_sel,
   output logic    o_capture
);

   state_e r_state;
   state_e w_state_nxt;
   logic   r_drop;
   logic   w_drop_nxt;

   // State and drop flag registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Next-state, drop and datapath control; redirect has priority in every state
   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop;
      o_fpc_sel   = PC_KEEP;
      o_npc_sel   = PC_KEEP;
      o_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // The pending request keeps its address; the target waits in next_pc
            if (i_redirect) begin
               o_npc_sel  = PC_TGT;
               w_drop_nxt = 1'b1;
            end
            if (i_req_ready)
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_redirect) begin
               if (i_resp_valid) begin
                  // Response arrives with the redirect: nothing left to drop
                  o_fpc_sel   = PC_TGT;
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end else begin
                  o_npc_sel  = PC_TGT;
                  w_drop_nxt = 1'b1;
               end
            end else if (i_resp_valid) begin
               if (r_drop) begin
                  o_fpc_sel   = PC_NEXT;
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end else begin
                  o_capture   = 1'b1;
                  o_npc_sel   = PC_INC;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (i_redirect) begin
               o_fpc_sel   = PC_TGT;
               w_state_nxt = S_IDLE;
            end else if (i_ready) begin
               o_fpc_sel   = PC_NEXT;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_req_valid = (r_state == S_IDLE);
   assign o_valid     = (r_state == S_HOLD);

endmodule

// File: rtl/ifu_fetch_reg.sv
// Generic enabled register with synchronous active-high reset to a constant.
module regTemplate #(
   parameter int unsigned  W       = 32,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   // Reset to RST_VAL, otherwise load i_d when enabled
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_q <= RST_VAL;
      else if (i_en)
         o_q <= i_d;
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// holds the returned instruction for the IF/ID register, and handles redirects.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [INST_LEN-1:0] imem_resp_data,
   input  logic                i_redirect,
   input  logic [XLEN-1:0]     i_redirect_pc,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [XLEN-1:0]     o_inst_addr,
   output logic [INST_LEN-1:0] o_inst_data
);

   pc_sel_e         w_fpc_sel;
   pc_sel_e         w_npc_sel;
   logic            w_capture;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_next_pc;
   logic [XLEN-1:0] w_fpc_d;
   logic [XLEN-1:0] w_npc_d;
   logic            w_unused_redirect_lsbs;

   assign w_target               = {i_redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused_redirect_lsbs = ^i_redirect_pc[1:0];

   ifu_fsm u_fsm (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_ready  (imem_req_ready),
      .i_resp_valid (imem_resp_valid),
      .i_redirect   (i_redirect),
      .i_ready      (i_ready),
      .o_req_valid  (imem_req_valid),
      .o_valid      (o_valid),
      .o_fpc_sel    (w_fpc_sel),
      .o_npc_sel    (w_npc_sel),
      .o_capture    (w_capture)
   );

   // PC register input muxes; the increment wraps at XLEN bits
   always_comb begin
      w_fpc_d = r_next_pc;
      if (w_fpc_sel == PC_TGT)
         w_fpc_d = w_target;
      w_npc_d = r_fetch_pc + XLEN'(4);
      if (w_npc_sel == PC_TGT)
         w_npc_d = w_target;
   end

   regTemplate #(.W(XLEN), .RST_VAL(RESET_PC)) u_fetch_pc (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_fpc_sel != PC_KEEP),
      .i_d   (w_fpc_d),
      .o_q   (r_fetch_pc)
   );

   regTemplate #(.W(XLEN), .RST_VAL(RESET_PC)) u_next_pc (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_npc_sel != PC_KEEP),
      .i_d   (w_npc_d),
      .o_q   (r_next_pc)
   );

   regTemplate #(.W(XLEN), .RST_VAL('0)) u_inst_addr (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_capture),
      .i_d   (r_fetch_pc),
      .o_q   (o_inst_addr)
   );

   regTemplate #(.W(INST_LEN), .RST_VAL(INST_NOP)) u_inst_data (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_capture),
      .i_d   (imem_resp_data),
      .o_q   (o_inst_data)
   );

   assign imem_req_addr = r_fetch_pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, fetch, backpressure, redirects in each
// state, redirect alignment, PC wrap and stale responses after reset.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready;

   logic        a_req_valid, a_valid;
   logic [31:0] a_req_addr, a_inst_addr, a_inst_data;
   logic        b_req_valid, b_valid;
   logic [31:0] b_req_addr, b_inst_addr, b_inst_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (a_req_valid),
      .imem_req_ready  (req_ready),
      .imem_req_addr   (a_req_addr),
      .imem_resp_valid (resp_valid),
      .imem_resp_data  (resp_data),
      .i_redirect      (redirect),
      .i_redirect_pc   (redirect_pc),
      .o_valid         (a_valid),
      .i_ready         (ready),
      .o_inst_addr     (a_inst_addr),
      .o_inst_data     (a_inst_data)
   );

   ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (b_req_valid),
      .imem_req_ready  (req_ready),
      .imem_req_addr   (b_req_addr),
      .imem_resp_valid (resp_valid),
      .imem_resp_data  (resp_data),
      .i_redirect      (redirect),
      .i_redirect_pc   (redirect_pc),
      .o_valid         (b_valid),
      .i_ready         (ready),
      .o_inst_addr     (b_inst_addr),
      .o_inst_data     (b_inst_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
      redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_req_valid", a_req_valid, 1);
      chk("rst_req_addr", a_req_addr, 32'h8000_0000);
      chk("rst_o_valid", a_valid, 0);
      chk("rst_inst_addr", a_inst_addr, 32'h0);
      chk("rst_inst_data", a_inst_data, 32'h0000_0013);
      chk("rst_wrap_addr", b_req_addr, 32'hFFFF_FFFC);

      // Reset-then-fetch
      rst = 1'b0; req_ready = 1'b1;
      tick();
      chk("f1_wait_no_req", a_req_valid, 0);
      req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0000_0013;
      tick();
      chk("f1_o_valid", a_valid, 1);
      chk("f1_inst_addr", a_inst_addr, 32'h8000_0000);
      chk("f1_inst_data", a_inst_data, 32'h0000_0013);
      chk("f1_hold_no_req", a_req_valid, 0);
      chk("f1_wrap_inst_addr", b_inst_addr, 32'hFFFF_FFFC);
      resp_valid = 1'b0; ready = 1'b1;
      tick();
      chk("f1_o_valid_clr", a_valid, 0);
      chk("f1_next_req", a_req_valid, 1);
      chk("f1_next_addr", a_req_addr, 32'h8000_0004);
      chk("f1_inst_addr_kept", a_inst_addr, 32'h8000_0000);
      chk("wrap_next_addr", b_req_addr, 32'h0000_0000);
      ready = 1'b0;

      // Backpressure on the second instruction
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
      tick();
      chk("bp_o_valid", a_valid, 1);
      chk("bp_inst_addr", a_inst_addr, 32'h8000_0004);
      chk("bp_inst_data", a_inst_data, 32'hDEAD_BEEF);
      resp_data = 32'h1111_1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", a_valid, 1);
         chk("bp_hold_addr", a_inst_addr, 32'h8000_0004);
         chk("bp_hold_data", a_inst_data, 32'hDEAD_BEEF);
         chk("bp_hold_no_req", a_req_valid, 0);
      end
      resp_valid = 1'b0; ready = 1'b1;
      tick();
      chk("bp_release_valid", a_valid, 0);
      chk("bp_release_req", a_req_valid, 1);
      chk("bp_release_addr", a_req_addr, 32'h8000_0008);
      ready = 1'b0;

      // Redirect in WAIT before the response
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_0100;
      tick();
      chk("rw_still_wait", a_req_valid, 0);
      redirect = 1'b0; resp_valid = 1'b1; resp_data = 32'hBAD0_0001;
      tick();
      chk("rw_dropped_valid", a_valid, 0);
      chk("rw_req_valid", a_req_valid, 1);
      chk("rw_req_addr", a_req_addr, 32'h8000_0100);
      chk("rw_data_kept", a_inst_data, 32'hDEAD_BEEF);
      resp_valid = 1'b0;

      // Redirect coincident with the response in WAIT
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hBAD0_0002;
      redirect = 1'b1; redirect_pc = 32'h8000_0200;
      tick();
      chk("rc_valid", a_valid, 0);
      chk("rc_req_addr", a_req_addr, 32'h8000_0200);
      chk("rc_data_kept", a_inst_data, 32'hDEAD_BEEF);
      redirect = 1'b0; resp_valid = 1'b0;
      // Drop must be clear: the next response is delivered
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0000_0A13;
      tick();
      chk("rc_deliver_valid", a_valid, 1);
      chk("rc_deliver_addr", a_inst_addr, 32'h8000_0200);
      chk("rc_deliver_data", a_inst_data, 32'h0000_0A13);

      // Redirect in HOLD with i_ready, unaligned target
      resp_valid = 1'b0; ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0103;
      tick();
      chk("rh_valid", a_valid, 0);
      chk("rh_req_valid", a_req_valid, 1);
      chk("rh_req_addr", a_req_addr, 32'h8000_0100);
      chk("rh_inst_addr_kept", a_inst_addr, 32'h8000_0200);
      ready = 1'b0; redirect = 1'b0;

      // Redirect in IDLE while the request is unaccepted
      redirect = 1'b1; redirect_pc = 32'h8000_0300;
      tick();
      chk("ri_req_valid", a_req_valid, 1);
      chk("ri_req_addr_kept", a_req_addr, 32'h8000_0100);
      redirect = 1'b0; req_ready = 1'b1;
      tick();
      req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hBAD0_0003;
      tick();
      chk("ri_dropped_valid", a_valid, 0);
      chk("ri_req_addr", a_req_addr, 32'h8000_0300);
      resp_valid = 1'b0;

      // Reset overrides an in-flight request; stale response afterwards ignored
      req_ready = 1'b1;
      tick();
      rst = 1'b1; req_ready = 1'b0;
      tick();
      chk("rr_req_valid", a_req_valid, 1);
      chk("rr_req_addr", a_req_addr, 32'h8000_0000);
      chk("rr_inst_addr", a_inst_addr, 32'h0);
      chk("rr_inst_data", a_inst_data, 32'h0000_0013);
      rst = 1'b0; resp_valid = 1'b1; resp_data = 32'hBAD0_0004;
      tick();
      chk("stale_valid", a_valid, 0);
      chk("stale_req_valid", a_req_valid, 1);
      chk("stale_req_addr", a_req_addr, 32'h8000_0000);
      chk("stale_data", a_inst_data, 32'h0000_0013);
      resp_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
